// File: rtl/eth_axis_frame_gen.sv
// eth_axis_frame_gen
//   Synthetic Ethernet frame source for the user side of the 10G MAC TX path.
//   Emits numbered frames of programmable length and inter-frame gap. Each
//   frame carries a dst/src/ethertype header, a 32-bit big-endian sequence
//   number in bytes 14..17, and payload byte i = i[7:0] from byte 18 onward.
//
// Ports
//   clk, rst_n          logic clock, asynchronous active-low reset
//   m_axis_*            AXI-stream master; byte lane k = frame byte KB*beat+k
//   m_axis_tuser[0]     bad-frame flag, only on the last beat
//   cfg_enable          level; generation runs while high
//   cfg_frame_len       frame length in bytes excluding FCS (clamped 18..16383)
//   cfg_frame_count     frames per run, 0 = continuous
//   cfg_gap             idle cycles between frames
//   cfg_dst_mac/src_mac/ethertype   header fields, latched at run start
//   cfg_bad_frame       mark the next started frame bad
//   stat_busy           frame in progress or gap counting
//   stat_frames_sent    frames completed since run start
//   stat_done           one-cycle pulse when the requested count completes

module eth_axis_frame_gen #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_frame_len,
  input  logic [31:0]           cfg_frame_count,
  input  logic [7:0]            cfg_gap,
  input  logic [47:0]           cfg_dst_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [15:0]           cfg_ethertype,
  input  logic                  cfg_bad_frame,

  output logic                  stat_busy,
  output logic [31:0]           stat_frames_sent,
  output logic                  stat_done
);

  localparam int unsigned KB_LOG2 = $clog2(KEEP_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Run-level latched configuration
  logic [31:0] count_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [15:0] type_q;
  logic [31:0] seq_q;
  logic [31:0] sent_q;

  // Frame-level latched configuration and position
  logic [13:0] len_q;
  logic        bad_q;
  logic [15:0] beat_q;
  logic [7:0]  gap_q;

  logic        busy_q;
  logic        done_q;

  // FSM control strobes
  logic start_run;
  logic new_frame;
  logic load_beat;
  logic gap_load;
  logic done_set;

  logic        hs;
  logic        last_hs;
  logic [31:0] sent_inc;

  // Next-beat generator inputs
  logic [15:0] gen_beat;
  logic [15:0] beat_base;
  logic [15:0] last_beat;
  logic [13:0] gen_len;
  logic        gen_bad;
  logic [31:0] gen_seq;
  logic [47:0] gen_dst;
  logic [47:0] gen_src;
  logic [15:0] gen_type;

  logic [DATA_WIDTH-1:0] gen_data;
  logic [KEEP_WIDTH-1:0] gen_keep;
  logic                  gen_last;

  function automatic logic [13:0] clamp_len(input logic [15:0] l);
    if (l < 16'd18)
      return 14'd18;
    else if (l > 16'd16383)
      return 14'd16383;
    else
      return l[13:0];
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [15:0] idx,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] etype,
    input logic [31:0] seq
  );
    if (idx < 16'd6)
      return 8'(dst >> {(16'd5 - idx), 3'b000});
    else if (idx < 16'd12)
      return 8'(src >> {(16'd11 - idx), 3'b000});
    else if (idx < 16'd14)
      return 8'(etype >> {(16'd13 - idx), 3'b000});
    else if (idx < 16'd18)
      return 8'(seq >> {(16'd17 - idx), 3'b000});
    else
      return idx[7:0];
  endfunction

  assign hs       = m_axis_tvalid & m_axis_tready;
  assign last_hs  = hs & m_axis_tlast;
  assign sent_inc = sent_q + 32'd1;

  // Next-state and control
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    new_frame = 1'b0;
    load_beat = 1'b0;
    gap_load  = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          start_run = 1'b1;
          new_frame = 1'b1;
          load_beat = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (!m_axis_tlast) begin
            load_beat = 1'b1;
          end else if ((count_q != 32'd0) && (sent_inc == count_q)) begin
            done_set = 1'b1;
            state_d  = ST_DONE;
          end else if (!cfg_enable) begin
            state_d = ST_IDLE;
          end else if (cfg_gap == 8'd0) begin
            new_frame = 1'b1;
            load_beat = 1'b1;
          end else begin
            gap_load = 1'b1;
            state_d  = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // gap_q was loaded with cfg_gap on entry, so the value 1 marks the
        // last idle cycle; the first beat is registered on that edge.
        if (gap_q <= 8'd1) begin
          if (!cfg_enable) begin
            state_d = ST_IDLE;
          end else begin
            new_frame = 1'b1;
            load_beat = 1'b1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        if (!cfg_enable)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sources for the beat about to be registered. A run start takes header
  // fields straight from cfg since they are being latched on the same edge;
  // a back-to-back frame start sees the sequence number one ahead of seq_q.
  always_comb begin
    gen_beat = new_frame ? 16'd0 : (beat_q + 16'd1);
    gen_len  = new_frame ? clamp_len(cfg_frame_len) : len_q;
    gen_bad  = new_frame ? cfg_bad_frame : bad_q;
    gen_dst  = start_run ? cfg_dst_mac : dst_q;
    gen_src  = start_run ? cfg_src_mac : src_q;
    gen_type = start_run ? cfg_ethertype : type_q;
    if (start_run)
      gen_seq = 32'd0;
    else if (last_hs)
      gen_seq = seq_q + 32'd1;
    else
      gen_seq = seq_q;
  end

  assign beat_base = gen_beat << KB_LOG2;
  assign last_beat = ({2'b00, gen_len} - 16'd1) >> KB_LOG2;
  assign gen_last  = (gen_beat == last_beat);

  // Lanes past the frame end stay zero with keep cleared, which yields the
  // partial keep mask on the last beat without a separate remainder path.
  always_comb begin
    gen_data = '0;
    gen_keep = '0;
    for (int unsigned k = 0; k < KEEP_WIDTH; k++) begin
      if ((beat_base + 16'(k)) < {2'b00, gen_len}) begin
        gen_keep[k]       = 1'b1;
        gen_data[8*k +: 8] = frame_byte(beat_base + 16'(k), gen_dst, gen_src,
                                        gen_type, gen_seq);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      dst_q         <= '0;
      src_q         <= '0;
      type_q        <= '0;
      seq_q         <= '0;
      sent_q        <= '0;
      len_q         <= 14'd18;
      bad_q         <= 1'b0;
      beat_q        <= '0;
      gap_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (start_run) begin
        count_q <= cfg_frame_count;
        dst_q   <= cfg_dst_mac;
        src_q   <= cfg_src_mac;
        type_q  <= cfg_ethertype;
        seq_q   <= '0;
        sent_q  <= '0;
      end else if (last_hs) begin
        seq_q  <= seq_q + 32'd1;
        sent_q <= sent_inc;
      end

      if (new_frame) begin
        len_q <= gen_len;
        bad_q <= gen_bad;
      end

      if (gap_load)
        gap_q <= cfg_gap;
      else if ((state_q == ST_GAP) && (gap_q != 8'd0))
        gap_q <= gap_q - 8'd1;

      if (load_beat) begin
        m_axis_tdata  <= gen_data;
        m_axis_tkeep  <= gen_keep;
        m_axis_tlast  <= gen_last;
        m_axis_tuser  <= USER_WIDTH'(gen_last & gen_bad);
        m_axis_tvalid <= 1'b1;
        beat_q        <= gen_beat;
      end else if (hs) begin
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= '0;
        m_axis_tvalid <= 1'b0;
      end

      busy_q <= (state_d == ST_SEND) || (state_d == ST_GAP);
      done_q <= done_set;
    end
  end

  assign stat_busy        = busy_q;
  assign stat_frames_sent = sent_q;
  assign stat_done        = done_q;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
module tb_eth_axis_frame_gen;

  localparam logic [47:0] DST   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_02;
  localparam logic [15:0] ETYPE = 16'h88B5;

  localparam logic [127:0] T1_BEAT0 = 128'h0000B588020000000002010000000002;
  localparam logic [127:0] T1_BEAT1 = 128'h1F1E1D1C1B1A19181716151413120000;
  localparam logic [127:0] T1_BEAT3 = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [127:0] T2_BEAT3 = 128'h0000003C3B3A39383736353433323130;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  m_axis_tdata;
  logic [15:0]   m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          cfg_enable;
  logic [15:0]   cfg_frame_len;
  logic [31:0]   cfg_frame_count;
  logic [7:0]    cfg_gap;
  logic [47:0]   cfg_dst_mac;
  logic [47:0]   cfg_src_mac;
  logic [15:0]   cfg_ethertype;
  logic          cfg_bad_frame;
  logic          stat_busy;
  logic [31:0]   stat_frames_sent;
  logic          stat_done;

  always #5 clk = ~clk;

  eth_axis_frame_gen #(
    .DATA_WIDTH(128),
    .KEEP_WIDTH(16),
    .USER_WIDTH(1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .cfg_enable       (cfg_enable),
    .cfg_frame_len    (cfg_frame_len),
    .cfg_frame_count  (cfg_frame_count),
    .cfg_gap          (cfg_gap),
    .cfg_dst_mac      (cfg_dst_mac),
    .cfg_src_mac      (cfg_src_mac),
    .cfg_ethertype    (cfg_ethertype),
    .cfg_bad_frame    (cfg_bad_frame),
    .stat_busy        (stat_busy),
    .stat_frames_sent (stat_frames_sent),
    .stat_done        (stat_done)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [127:0] bd [128];
  logic [15:0]  bk [128];
  logic         bl [128];
  logic         bu [128];
  int unsigned  nbeats;
  int unsigned  stall_viol;
  int unsigned  drop_viol;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int unsigned i);
    logic [127:0] w;
    w = bd[i / 16];
    return 8'(w >> (8 * (i % 16)));
  endfunction

  function automatic logic [31:0] rx_seq();
    return {rx_byte(14), rx_byte(15), rx_byte(16), rx_byte(17)};
  endfunction

  function automatic logic [7:0] exp_byte(input int unsigned i, input logic [31:0] seq);
    if (i < 6)       return 8'(DST >> (8 * (5 - i)));
    else if (i < 12) return 8'(SRC >> (8 * (11 - i)));
    else if (i < 14) return 8'(ETYPE >> (8 * (13 - i)));
    else if (i < 18) return 8'(seq >> (8 * (17 - i)));
    else             return 8'(i);
  endfunction

  task automatic payload_mismatches(input int unsigned len, input logic [31:0] seq,
                                    output int unsigned bad);
    bad = 0;
    for (int unsigned i = 0; i < len; i++)
      if (rx_byte(i) !== exp_byte(i, seq)) bad++;
  endtask

  task automatic recv_frame(input bit throttle, input int unsigned drop_at,
                            input int unsigned budget);
    bit got_last;
    bit stalled;
    logic [127:0] sd;
    logic [15:0]  sk;
    logic         sl;
    logic         su;
    got_last = 1'b0;
    stalled  = 1'b0;
    sd = '0; sk = '0; sl = 1'b0; su = 1'b0;
    nbeats = 0; stall_viol = 0; drop_viol = 0;
    for (int unsigned c = 0; c < budget && !got_last; c++) begin
      @(negedge clk);
      if (stalled) begin
        if (!m_axis_tvalid) drop_viol++;
        else if (m_axis_tdata !== sd || m_axis_tkeep !== sk ||
                 m_axis_tlast !== sl || m_axis_tuser[0] !== su) stall_viol++;
      end
      m_axis_tready = throttle ? 1'($urandom_range(1, 0)) : 1'b1;
      stalled = m_axis_tvalid && !m_axis_tready;
      sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast; su = m_axis_tuser[0];
      if (m_axis_tvalid && m_axis_tready) begin
        if (nbeats < 128) begin
          bd[nbeats] = m_axis_tdata;
          bk[nbeats] = m_axis_tkeep;
          bl[nbeats] = m_axis_tlast;
          bu[nbeats] = m_axis_tuser[0];
        end
        nbeats++;
        if (m_axis_tlast) got_last = 1'b1;
        if (drop_at != 0 && nbeats == drop_at) cfg_enable = 1'b0;
      end
    end
    chk("rx_frame_complete", 128'(got_last), 128'd1);
  endtask

  // Holds tready low so the next frame's first beat stays presented.
  task automatic measure_gap(output int unsigned g);
    bit found;
    found = 1'b0;
    g = 0;
    for (int unsigned c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      m_axis_tready = 1'b0;
      if (m_axis_tvalid) found = 1'b1;
      else g++;
    end
    chk("gap_timeout", 128'(found), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned g;
    int unsigned bad;
    int unsigned cnt;

    rst_n           = 1'b0;
    m_axis_tready   = 1'b0;
    cfg_enable      = 1'b0;
    cfg_frame_len   = 16'd64;
    cfg_frame_count = 32'd1;
    cfg_gap         = 8'd0;
    cfg_dst_mac     = DST;
    cfg_src_mac     = SRC;
    cfg_ethertype   = ETYPE;
    cfg_bad_frame   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("rst_tlast",  128'(m_axis_tlast),  128'd0);
    chk("rst_tuser",  128'(m_axis_tuser),  128'd0);
    chk("rst_tdata",  m_axis_tdata,        128'd0);
    chk("rst_tkeep",  128'(m_axis_tkeep),  128'd0);
    chk("rst_busy",   128'(stat_busy),     128'd0);
    chk("rst_sent",   128'(stat_frames_sent), 128'd0);
    chk("rst_done",   128'(stat_done),     128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: len 64, one frame, 4 beats
    cfg_enable = 1'b1;
    @(negedge clk);
    chk("t1_latency_tvalid", 128'(m_axis_tvalid), 128'd1);
    chk("t1_busy",           128'(stat_busy),     128'd1);
    chk("t1_beat0_presented", m_axis_tdata,       T1_BEAT0);
    recv_frame(1'b0, 0, 50);
    chk("t1_nbeats",   128'(nbeats), 128'd4);
    chk("t1_beat0",    bd[0], T1_BEAT0);
    chk("t1_beat1",    bd[1], T1_BEAT1);
    chk("t1_beat3",    bd[3], T1_BEAT3);
    chk("t1_keep3",    128'(bk[3]), 128'hFFFF);
    chk("t1_last2",    128'(bl[2]), 128'd0);
    chk("t1_last3",    128'(bl[3]), 128'd1);
    chk("t1_user3",    128'(bu[3]), 128'd0);
    chk("t1_seq",      128'(rx_seq()), 128'd0);
    @(negedge clk);
    chk("t1_done_pulse", 128'(stat_done), 128'd1);
    chk("t1_sent",       128'(stat_frames_sent), 128'd1);
    chk("t1_tvalid_off", 128'(m_axis_tvalid), 128'd0);
    @(negedge clk);
    chk("t1_done_clear", 128'(stat_done), 128'd0);
    chk("t1_busy_done",  128'(stat_busy), 128'd0);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);

    // T2: len 61, count 3, gap 5
    cfg_frame_len   = 16'd61;
    cfg_frame_count = 32'd3;
    cfg_gap         = 8'd5;
    cfg_enable      = 1'b1;
    for (int unsigned f = 0; f < 3; f++) begin
      recv_frame(1'b0, 0, 100);
      chk($sformatf("t2_nbeats_f%0d", f), 128'(nbeats), 128'd4);
      chk($sformatf("t2_keep3_f%0d", f), 128'(bk[3]), 128'h1FFF);
      chk($sformatf("t2_seq_f%0d", f), 128'(rx_seq()), 128'(f));
      if (f == 0) chk("t2_beat3", bd[3], T2_BEAT3);
      if (f < 2) begin
        measure_gap(g);
        chk($sformatf("t2_gap_f%0d", f), 128'(g), 128'd5);
      end
    end
    @(negedge clk);
    chk("t2_done", 128'(stat_done), 128'd1);
    chk("t2_sent", 128'(stat_frames_sent), 128'd3);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);

    // T3: throttled tready, len 1500, count 10
    cfg_frame_len   = 16'd1500;
    cfg_frame_count = 32'd10;
    cfg_gap         = 8'd3;
    cfg_enable      = 1'b1;
    for (int unsigned f = 0; f < 10; f++) begin
      recv_frame(1'b1, 0, 4000);
      payload_mismatches(1500, 32'(f), bad);
      chk($sformatf("t3_payload_f%0d", f), 128'(bad), 128'd0);
      chk($sformatf("t3_stable_f%0d", f), 128'(stall_viol), 128'd0);
      chk($sformatf("t3_nodrop_f%0d", f), 128'(drop_viol), 128'd0);
      chk($sformatf("t3_nbeats_f%0d", f), 128'(nbeats), 128'd94);
      chk($sformatf("t3_keeplast_f%0d", f), 128'(bk[93]), 128'h0FFF);
    end
    @(negedge clk);
    chk("t3_done", 128'(stat_done), 128'd1);
    chk("t3_sent", 128'(stat_frames_sent), 128'd10);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);

    // T4: len 10 clamps to 18, bad frame
    cfg_frame_len   = 16'd10;
    cfg_frame_count = 32'd1;
    cfg_gap         = 8'd0;
    cfg_bad_frame   = 1'b1;
    cfg_enable      = 1'b1;
    recv_frame(1'b0, 0, 50);
    chk("t4_nbeats", 128'(nbeats), 128'd2);
    chk("t4_beat0",  bd[0], T1_BEAT0);
    chk("t4_beat1",  bd[1], 128'd0);
    chk("t4_keep1",  128'(bk[1]), 128'h0003);
    chk("t4_last1",  128'(bl[1]), 128'd1);
    chk("t4_user0",  128'(bu[0]), 128'd0);
    chk("t4_user1",  128'(bu[1]), 128'd1);
    @(negedge clk);
    chk("t4_done", 128'(stat_done), 128'd1);
    cfg_bad_frame = 1'b0;
    cfg_enable    = 1'b0;
    repeat (2) @(negedge clk);

    // T5: continuous, gap 0, enable dropped mid-frame
    cfg_frame_len   = 16'd64;
    cfg_frame_count = 32'd0;
    cfg_gap         = 8'd0;
    cfg_enable      = 1'b1;
    recv_frame(1'b0, 0, 50);
    chk("t5_seq_f0", 128'(rx_seq()), 128'd0);
    measure_gap(g);
    chk("t5_no_bubble", 128'(g), 128'd0);
    recv_frame(1'b0, 2, 50);
    chk("t5_nbeats_f1", 128'(nbeats), 128'd4);
    chk("t5_seq_f1",    128'(rx_seq()), 128'd1);
    chk("t5_last_f1",   128'(bl[3]), 128'd1);
    m_axis_tready = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_axis_tvalid) cnt++;
    end
    chk("t5_no_more_valid", 128'(cnt), 128'd0);
    chk("t5_busy",          128'(stat_busy), 128'd0);
    chk("t5_sent",          128'(stat_frames_sent), 128'd2);

    // T6: reset mid-frame, restart at sequence 0
    cfg_enable    = 1'b1;
    m_axis_tready = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_pre_sent",   128'(stat_frames_sent), 128'd1);
    chk("t6_pre_tvalid", 128'(m_axis_tvalid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t6_rst_sent",   128'(stat_frames_sent), 128'd0);
    chk("t6_rst_busy",   128'(stat_busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    recv_frame(1'b0, 0, 50);
    cfg_enable = 1'b0;
    chk("t6_nbeats", 128'(nbeats), 128'd4);
    chk("t6_seq",    128'(rx_seq()), 128'd0);
    repeat (3) @(negedge clk);
    chk("t6_idle_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("t6_sent",        128'(stat_frames_sent), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_axis_frame_gen.md
# eth_axis_frame_gen

Synthetic Ethernet frame source that drives the user-side AXI-stream transmit port of the 10G MAC/FIFO wrapper (the writer for `tx_axis_*`). It emits numbered frames of programmable length and inter-frame gap with a deterministic payload, so the traffic can be checked by a receiver on the far end of the link. It sits in the logic clock domain, directly ahead of the TX FIFO.

## Interface
- `DATA_WIDTH`, 128, AXIS data width; 64 or 128 legal
- `KEEP_WIDTH`, DATA_WIDTH/8, byte lanes per beat (KB)
- `USER_WIDTH`, 1, tuser width; bit 0 is the bad-frame flag, upper bits are driven 0
- `clk`  in  1  logic clock
- `rst_n`  in  1  asynchronous, active-low reset
- `m_axis_tdata`  out  DATA_WIDTH  frame data; byte lane k carries frame byte KB*beat+k
- `m_axis_tkeep`  out  KEEP_WIDTH  byte enables
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  sink ready
- `m_axis_tlast`  out  1  last beat of frame
- `m_axis_tuser`  out  USER_WIDTH  bit 0 = 1 marks the frame bad on its last beat
- `cfg_enable`  in  1  level; generation runs while high
- `cfg_frame_len`  in  16  frame length in bytes, excluding FCS
- `cfg_frame_count`  in  32  number of frames per run; 0 = continuous
- `cfg_gap`  in  8  idle cycles between frames
- `cfg_dst_mac`, `cfg_src_mac`  in  48 each  header addresses
- `cfg_ethertype`  in  16  header ethertype
- `cfg_bad_frame`  in  1  mark the next started frame bad
- `stat_busy`  out  1  a frame is in progress or a gap is counting
- `stat_frames_sent`  out  32  frames completed since the last run start
- `stat_done`  out  1  one-cycle pulse when `cfg_frame_count` frames have completed

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: when `cfg_enable`=1, latch `cfg_frame_count`, the MAC addresses and the ethertype, clear `stat_frames_sent` and the sequence number, then go to SEND.
- At the start of every frame, latch `cfg_frame_len` (clamped to the range 18..16383) and `cfg_bad_frame`.
- Frame bytes:
  - 0–5: dst MAC, MSB first.
  - 6–11: src MAC.
  - 12–13: ethertype.
  - 14–17: 32-bit sequence number, big-endian.
  - byte i ≥ 18: i[7:0].
- Beats per frame = ceil(len/KB). Every beat except the last has tkeep all ones. On the last beat, tkeep = the low (len mod KB) bits set, or all ones when the remainder is 0. Unused lanes are driven 0.
- `m_axis_tuser[0]` = latched bad flag, on the last beat only; 0 on all other beats.
- When the last beat is accepted:
  - increment `stat_frames_sent` and the sequence number (the sequence number wraps at 2^32);
  - if the count has been reached (count≠0 and sent==count), go to DONE;
  - else if `cfg_enable`=0, go to IDLE;
  - else if `cfg_gap`=0, go to SEND;
  - else go to GAP.
- GAP: count `cfg_gap` cycles, then go to SEND. If `cfg_enable`=0 at gap end, go to IDLE instead.
- DONE: pulse `stat_done` for one cycle, then hold until `cfg_enable`=0, then go to IDLE. A new run requires a fresh rising level of `cfg_enable`.
- Dropping `cfg_enable` mid-frame never truncates the frame. The current frame completes.

## Timing
- Reset (async assert, sync deassert assumed upstream) sets:
  - tvalid, tlast, tuser, tdata, tkeep = 0;
  - stat_busy = 0, stat_frames_sent = 0, stat_done = 0;
  - state = IDLE.
- Reset mid-frame drops tvalid immediately. The truncated frame is the sink's concern.
- Latency: `cfg_enable` sampled high in IDLE → tvalid=1 with the first beat on the next cycle.
- AXIS rules: once tvalid=1, tdata/tkeep/tlast/tuser are stable until tready=1. tvalid never drops without a handshake. Within SEND, tvalid is continuous.
- Back-to-back (gap 0): the first beat of frame n+1 is presented in the cycle after the last beat of frame n is accepted.
- Gap g>0: exactly g cycles with tvalid=0 between the accepting handshake and the next tvalid.
- `stat_busy` = 1 in SEND and GAP.
- `stat_frames_sent` updates the cycle after the last-beat handshake.
- `stat_done` asserts in the cycle after the final last-beat handshake.
- Fully registered outputs. Single-cycle beat throughput when tready is held high.

## Test plan
- DATA_WIDTH=128, len=64, count=1, dst=02:00:00:00:00:01, src=02:00:00:00:00:02, type=0x88B5, tready=1 → 4 beats.
  - Beat 0 bytes 14–17 = 00 00 00 00.
  - Beat 3 tkeep=0xFFFF, tlast=1.
  - stat_done pulses once; frames_sent=1.
- len=61, count=3, gap=5 → each frame is 4 beats with last tkeep=0x1FFF.
  - Exactly 5 idle cycles between frames.
  - Sequence numbers 0, 1, 2.
- Random tready throttling (50%), len=1500, count=10 → payload byte i = i[7:0] in every frame, no tvalid drop without handshake, data stable while stalled.
- len=10 → clamped to 18: 2 beats, last tkeep=0x0003. cfg_bad_frame=1 → tuser[0]=1 on the last beat only.
- count=0, gap=0, deassert cfg_enable mid-frame → the current frame completes, no further tvalid. The next frame starts with no bubble when enable is held.
- Assert rst_n=0 mid-frame → tvalid=0 and frames_sent=0 at once. After release with enable=1, a new run starts at sequence number 0.
